// File: rtl/rvm_mem_arbiter_pkg.sv
// Shared types for the fetch / load-store memory arbiter: FSM states, owner
// encodings and the round-robin pick function.
package rvm_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    // A lone requester always wins; under contention the side that did not win last time goes.
    function automatic owner_e pick_owner(input logic f_req, input logic d_req, input owner_e last);
        if (f_req && d_req) begin
            return (last == OWNER_FETCH) ? OWNER_DATA : OWNER_FETCH;
        end else if (d_req) begin
            return OWNER_DATA;
        end else begin
            return OWNER_FETCH;
        end
    endfunction

endpackage

// File: rtl/rvm_mem_arbiter_bus_timer.sv
// Saturating watchdog counter for the memory arbiter. expired is asserted on the
// TIMEOUT-th consecutive enabled cycle since the last clear; TIMEOUT=0 disables it.
module rvm_bus_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (TIMEOUT > 0) && (count_q != CNT_W'(TIMEOUT))) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment and an asynchronous reset
    // so every flop in the block updates from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            assign expired = enable && (count_q == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/rvm_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store, one transaction in flight, all outputs registered, bus watchdog.
module rvm_mem_arbiter
    import rvm_mem_arbiter_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [XLEN-1:0]   f_addr,
    output logic              f_rvalid,
    output logic [XLEN-1:0]   f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN/8-1:0] d_wstrb,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;   // current owner, doubles as last winner
    logic              drain_q, drain_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_wen_q, mem_wen_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN/8-1:0] mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              f_rvalid_q, f_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic              f_err_q, f_err_d, d_err_q, d_err_d;
    logic [XLEN-1:0]   f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;

    logic              resp_err;
    logic [XLEN-1:0]   resp_data;
    logic              timer_clear, timer_enable, timer_expired;

    rvm_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        drain_d     = drain_q;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        resp_err    = 1'b0;
        resp_data   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (f_req || d_req) begin
                    owner_d = pick_owner(f_req, d_req, owner_q);
                    state_d = ST_REQ;
                    if (owner_d == OWNER_DATA) begin
                        mem_addr_d  = d_addr;
                        mem_wen_d   = d_wen;
                        mem_wstrb_d = d_wen ? d_wstrb : '0;
                        mem_wdata_d = d_wen ? d_wdata : '0;
                    end else begin
                        mem_addr_d  = f_addr;
                        mem_wen_d   = 1'b0;
                        mem_wstrb_d = '0;
                        mem_wdata_d = '0;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = ST_WAIT;
                end else if (timer_expired) begin
                    state_d  = ST_RESP;
                    resp_err = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d   = ST_RESP;
                    resp_err  = mem_err;
                    resp_data = mem_wen_q ? '0 : mem_rdata;
                end else if (timer_expired) begin
                    // The memory still owes a response; it must be swallowed before re-arbitrating.
                    state_d  = ST_RESP;
                    resp_err = 1'b1;
                    drain_d  = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = drain_q ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (mem_rvalid || timer_expired) begin
                    state_d = ST_IDLE;
                    drain_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                drain_d = 1'b0;
            end
        endcase

        // Outputs are registered from the next state so they track the FSM without an input-to-output path.
        mem_req_d  = (state_d == ST_REQ);
        f_rvalid_d = (state_d == ST_RESP) && (owner_d == OWNER_FETCH);
        d_rvalid_d = (state_d == ST_RESP) && (owner_d == OWNER_DATA);
        f_err_d    = f_rvalid_d && resp_err;
        d_err_d    = d_rvalid_d && resp_err;
        f_rdata_d  = f_rvalid_d ? resp_data : '0;
        d_rdata_d  = d_rvalid_d ? resp_data : '0;

        timer_clear  = (state_d != state_q);
        timer_enable = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_FETCH;
            drain_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            f_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            f_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            drain_q     <= drain_d;
            mem_req_q   <= mem_req_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            f_rvalid_q  <= f_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            f_err_q     <= f_err_d;
            d_err_q     <= d_err_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
    assign f_rvalid  = f_rvalid_q;
    assign f_rdata   = f_rdata_q;
    assign f_err     = f_err_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_rvm_mem_arbiter.sv
// Directed bench for rvm_mem_arbiter (TIMEOUT=8): latency, round-robin order,
// stores, both timeout paths, drain behaviour and mid-transaction reset.
module tb_rvm_mem_arbiter;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 8;

    logic              clk, reset;
    logic              f_req, f_rvalid, f_err;
    logic [XLEN-1:0]   f_addr, f_rdata;
    logic              d_req, d_wen, d_rvalid, d_err;
    logic [XLEN-1:0]   d_addr, d_wdata, d_rdata;
    logic [XLEN/8-1:0] d_wstrb, mem_wstrb;
    logic              mem_req, mem_wen, mem_gnt, mem_rvalid, mem_err;
    logic [XLEN-1:0]   mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    rvm_mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f_req = 0; f_addr = '0;
        d_req = 0; d_wen = 0; d_addr = '0; d_wstrb = '0; d_wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        step();
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 32; i++) begin
            if (mem_req === 1'b1) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    // From a REQ cycle: accept, then respond the following cycle; returns in the RESP cycle.
    task automatic finish_txn(input logic [XLEN-1:0] rd, input logic e);
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        mem_rvalid = 1; mem_rdata = rd; mem_err = e;
        step();
        mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step();
        n_cmp++;
        if ({mem_req, mem_wen, mem_wstrb, f_rvalid, f_err, d_rvalid, d_err} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 0",
                     {mem_req, mem_wen, mem_wstrb, f_rvalid, f_err, d_rvalid, d_err});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, f_rdata, d_rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h required 0", {mem_addr, mem_wdata, f_rdata, d_rdata});
        end
        reset = 0;
        step();
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_req: got %b required 0", mem_req);
        end
    endtask

    task automatic test_lone_fetch();
        logic d_seen;
        d_seen = 0;
        f_req = 1; f_addr = 32'h100;              // cycle N
        step();                                   // N+1
        d_seen |= d_rvalid;
        n_cmp++;
        if ({mem_req, mem_wen, mem_wstrb} !== 6'b100000 || mem_addr !== 32'h100) begin
            n_err++;
            $display("FAIL fetch_req_n1: got req=%b wen=%b strb=%b addr=%h required 1 0 0000 00000100",
                     mem_req, mem_wen, mem_wstrb, mem_addr);
        end
        mem_gnt = 1;
        step();                                   // N+2
        d_seen |= d_rvalid;
        mem_gnt = 0;
        n_cmp++;
        if (mem_req !== 1'b0 || f_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_wait_n2: got req=%b rvalid=%b required 0 0", mem_req, f_rvalid);
        end
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        step();                                   // N+3
        d_seen |= d_rvalid;
        mem_rvalid = 0; mem_rdata = '0; f_req = 0;
        n_cmp++;
        if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF || f_err !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_resp_n3: got rvalid=%b rdata=%h err=%b required 1 deadbeef 0",
                     f_rvalid, f_rdata, f_err);
        end
        step();                                   // N+4
        d_seen |= d_rvalid;
        n_cmp++;
        if (f_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_pulse_width: got rvalid=%b at N+4 required 0", f_rvalid);
        end
        n_cmp++;
        if (d_seen !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_no_d_rvalid: got d_rvalid seen=%b required 0", d_seen);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        f_req = 1; f_addr = 32'h200;
        d_req = 1; d_addr = 32'h300; d_wen = 0;
        step();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            n_err++;
            $display("FAIL rr_first_data: got req=%b addr=%h required 1 00000300", mem_req, mem_addr);
        end
        finish_txn(32'h11, 1'b0);
        n_cmp++;
        if (d_rvalid !== 1'b1 || f_rvalid !== 1'b0 || d_rdata !== 32'h11) begin
            n_err++;
            $display("FAIL rr_first_resp: got d_rvalid=%b f_rvalid=%b d_rdata=%h required 1 0 00000011",
                     d_rvalid, f_rvalid, d_rdata);
        end
        wait_req(ok);
        n_cmp++;
        if (!ok || mem_addr !== 32'h200) begin
            n_err++;
            $display("FAIL rr_second_fetch: got ok=%b addr=%h required 1 00000200", ok, mem_addr);
        end
        finish_txn(32'h22, 1'b0);
        n_cmp++;
        if (f_rvalid !== 1'b1 || d_rvalid !== 1'b0 || f_rdata !== 32'h22) begin
            n_err++;
            $display("FAIL rr_second_resp: got f_rvalid=%b d_rvalid=%b f_rdata=%h required 1 0 00000022",
                     f_rvalid, d_rvalid, f_rdata);
        end
        wait_req(ok);
        n_cmp++;
        if (!ok || mem_addr !== 32'h300) begin
            n_err++;
            $display("FAIL rr_third_data: got ok=%b addr=%h required 1 00000300", ok, mem_addr);
        end
        finish_txn(32'h33, 1'b1);
        f_req = 0; d_req = 0;
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h33) begin
            n_err++;
            $display("FAIL rr_third_resp_err: got rvalid=%b err=%b rdata=%h required 1 1 00000033",
                     d_rvalid, d_err, d_rdata);
        end
        step();
    endtask

    task automatic test_store();
        bit ok;
        d_req = 1; d_wen = 1; d_addr = 32'h40; d_wstrb = 4'b0011; d_wdata = 32'h1234;
        wait_req(ok);
        n_cmp++;
        if (!ok || mem_wen !== 1'b1 || mem_wstrb !== 4'b0011 || mem_wdata !== 32'h1234 || mem_addr !== 32'h40) begin
            n_err++;
            $display("FAIL store_fields: got ok=%b wen=%b strb=%b wdata=%h addr=%h required 1 1 0011 00001234 00000040",
                     ok, mem_wen, mem_wstrb, mem_wdata, mem_addr);
        end
        finish_txn(32'hCAFEF00D, 1'b0);
        d_req = 0; d_wen = 0;
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_err !== 1'b0) begin
            n_err++;
            $display("FAIL store_resp: got rvalid=%b rdata=%h err=%b required 1 00000000 0",
                     d_rvalid, d_rdata, d_err);
        end
        step();
    endtask

    task automatic test_req_timeout();
        bit ok;
        int cycles;
        f_req = 1; f_addr = 32'h500;
        mem_rdata = 32'h5555AAAA;
        wait_req(ok);
        cycles = ok ? 1 : 0;
        for (int i = 0; i < 20 && ok; i++) begin
            step();
            if (mem_req === 1'b1) cycles++;
            else break;
        end
        f_req = 0; mem_rdata = '0;
        n_cmp++;
        if (cycles != TIMEOUT) begin
            n_err++;
            $display("FAIL req_timeout_len: got mem_req high %0d cycles required %0d", cycles, TIMEOUT);
        end
        n_cmp++;
        if (f_rvalid !== 1'b1 || f_err !== 1'b1 || f_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL req_timeout_resp: got rvalid=%b err=%b rdata=%h required 1 1 00000000",
                     f_rvalid, f_err, f_rdata);
        end
        step();
    endtask

    task automatic test_wait_timeout_drain();
        bit ok;
        int cycles;
        f_req = 1; f_addr = 32'h600;
        wait_req(ok);
        d_req = 1; d_wen = 0; d_addr = 32'h700;
        mem_gnt = 1;
        step();                                   // first WAIT cycle
        mem_gnt = 0;
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cycles++;
            if (f_rvalid === 1'b1) break;
        end
        f_req = 0;
        n_cmp++;
        if (cycles != TIMEOUT || f_err !== 1'b1 || f_rdata !== 32'h0 || d_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL wait_timeout_resp: got cycles=%0d err=%b rdata=%h d_rvalid=%b required %0d 1 00000000 0",
                     cycles, f_err, f_rdata, d_rvalid, TIMEOUT);
        end
        step();
        step();
        step();                                   // third DRAIN cycle
        n_cmp++;
        if (mem_req !== 1'b0 || d_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_holds_off: got mem_req=%b d_rvalid=%b required 0 0", mem_req, d_rvalid);
        end
        mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        step();                                   // IDLE
        mem_rvalid = 0; mem_rdata = '0;
        n_cmp++;
        if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL drain_swallow: got f_rvalid=%b d_rvalid=%b mem_req=%b required 0 0 0",
                     f_rvalid, d_rvalid, mem_req);
        end
        step();                                   // REQ for the waiting load
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h700) begin
            n_err++;
            $display("FAIL drain_then_data: got mem_req=%b addr=%h required 1 00000700", mem_req, mem_addr);
        end
        finish_txn(32'h77, 1'b0);
        d_req = 0;
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h77 || d_err !== 1'b0) begin
            n_err++;
            $display("FAIL drain_data_resp: got rvalid=%b rdata=%h err=%b required 1 00000077 0",
                     d_rvalid, d_rdata, d_err);
        end
        step();
    endtask

    task automatic test_drain_expiry();
        bit ok;
        int cycles;
        f_req = 1; f_addr = 32'h800;
        wait_req(ok);
        d_req = 1; d_wen = 0; d_addr = 32'h900;
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (f_rvalid === 1'b1) break;
        end
        f_req = 0;
        // RESP, 8 DRAIN cycles, IDLE, then REQ for the load.
        cycles = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            cycles++;
            if (mem_req === 1'b1) break;
        end
        n_cmp++;
        if (cycles != TIMEOUT + 2 || mem_addr !== 32'h900) begin
            n_err++;
            $display("FAIL drain_expiry: got cycles=%0d addr=%h required %0d 00000900",
                     cycles, mem_addr, TIMEOUT + 2);
        end
        finish_txn(32'h99, 1'b0);
        d_req = 0;
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h99) begin
            n_err++;
            $display("FAIL drain_expiry_resp: got rvalid=%b rdata=%h required 1 00000099", d_rvalid, d_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        logic any_rvalid;
        f_req = 1; f_addr = 32'hA00;
        wait_req(ok);
        mem_gnt = 1;
        step();                                   // WAIT
        mem_gnt = 0;
        reset = 1;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || f_rvalid !== 1'b0 || f_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_wait: got req=%b addr=%h rvalid=%b rdata=%h required 0 0 0 0",
                     mem_req, mem_addr, f_rvalid, f_rdata);
        end
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        step();
        reset = 0; f_req = 0;
        any_rvalid = f_rvalid | d_rvalid;
        step();                                   // IDLE with a stray response present
        any_rvalid |= f_rvalid | d_rvalid;
        mem_rvalid = 0; mem_rdata = '0;
        step();
        any_rvalid |= f_rvalid | d_rvalid;
        step();
        any_rvalid |= f_rvalid | d_rvalid;
        n_cmp++;
        if (any_rvalid !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_resp: got rvalid seen=%b mem_req=%b required 0 0", any_rvalid, mem_req);
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_lone_fetch();
        test_round_robin();
        test_store();
        test_req_timeout();
        test_wait_timeout_drain();
        test_drain_expiry();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
